// File: rtl/mem_req_issue.sv
//------------------------------------------------------------------------------
// mem_req_issue - in-order request FIFO with credit-limited issue to memory_controller (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module mem_req_issue #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_RD_OUT = 4,
  parameter int MAX_WR_OUT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // client request port
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  // controller write request / ack
  output logic [ADDR_W-1:0]           wr_address,
  output logic                        wr_en,
  output logic [DATA_W-1:0]           wr_data,
  input  logic [ADDR_W-1:0]           wr_ret_address,
  input  logic                        wr_ret_ack,
  // controller read request / ack
  output logic [ADDR_W-1:0]           rd_address,
  output logic                        rd_en,
  input  logic [DATA_W-1:0]           rd_ret_data,
  input  logic [ADDR_W-1:0]           rd_ret_address,
  input  logic                        rd_ret_ack,
  // client completions
  output logic                        rd_resp_valid,
  output logic [ADDR_W-1:0]           rd_resp_addr,
  output logic [DATA_W-1:0]           rd_resp_data,
  output logic                        wr_done,
  output logic [ADDR_W-1:0]           wr_done_addr,
  // status
  output logic [$clog2(MAX_RD_OUT):0] rd_outstanding,
  output logic [$clog2(MAX_WR_OUT):0] wr_outstanding,
  output logic                        idle,
  output logic                        proto_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RD_CW = $clog2(MAX_RD_OUT) + 1;
  localparam int WR_CW = $clog2(MAX_WR_OUT) + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [RD_CW-1:0] RD_LIMIT  = RD_CW'(MAX_RD_OUT);
  localparam logic [WR_CW-1:0] WR_LIMIT  = WR_CW'(MAX_WR_OUT);

  // FIFO storage and control
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push, pop, fifo_nonempty;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              issue_rd, issue_wr;

  // outstanding credit tracking
  logic [RD_CW-1:0]  rd_out_q, rd_out_d;
  logic [WR_CW-1:0]  wr_out_q, wr_out_d;
  logic              proto_err_q, proto_err_d;

  // registered controller and client outputs
  logic              rd_en_q, wr_en_q;
  logic [ADDR_W-1:0] rd_address_q, wr_address_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              rd_resp_valid_q, wr_done_q;
  logic [ADDR_W-1:0] rd_resp_addr_q, wr_done_addr_q;
  logic [DATA_W-1:0] rd_resp_data_q;

  assign req_ready     = (count_q != FIFO_FULL);
  assign fifo_nonempty = (count_q != '0);
  assign {head_we, head_addr, head_data} = mem_q[rd_ptr_q];

  // Only the head is ever considered, so a stalled head blocks everything behind it.
  always_comb begin
    push     = req_valid & req_ready;
    issue_rd = fifo_nonempty & ~head_we & (rd_out_q < RD_LIMIT);
    issue_wr = fifo_nonempty &  head_we & (wr_out_q < WR_LIMIT);
    pop      = issue_rd | issue_wr;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // An ack with nothing outstanding is a controller protocol violation; the counter
  // saturates at zero instead of wrapping.
  always_comb begin
    rd_out_d    = rd_out_q;
    wr_out_d    = wr_out_q;
    proto_err_d = proto_err_q;
    if (issue_rd && !rd_ret_ack) begin
      rd_out_d = rd_out_q + RD_CW'(1);
    end else if (!issue_rd && rd_ret_ack) begin
      if (rd_out_q == '0) begin
        proto_err_d = 1'b1;
      end else begin
        rd_out_d = rd_out_q - RD_CW'(1);
      end
    end
    if (issue_wr && !wr_ret_ack) begin
      wr_out_d = wr_out_q + WR_CW'(1);
    end else if (!issue_wr && wr_ret_ack) begin
      if (wr_out_q == '0) begin
        proto_err_d = 1'b1;
      end else begin
        wr_out_d = wr_out_q - WR_CW'(1);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_we, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_out_q    <= '0;
      wr_out_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_out_q    <= rd_out_d;
      wr_out_q    <= wr_out_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Issue stage: enables pulse for one cycle, address/data hold between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_address_q <= '0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
    end else begin
      rd_en_q <= issue_rd;
      wr_en_q <= issue_wr;
      if (issue_rd) begin
        rd_address_q <= head_addr;
      end
      if (issue_wr) begin
        wr_address_q <= head_addr;
        wr_data_q    <= head_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_valid_q <= 1'b0;
      rd_resp_addr_q  <= '0;
      rd_resp_data_q  <= '0;
      wr_done_q       <= 1'b0;
      wr_done_addr_q  <= '0;
    end else begin
      rd_resp_valid_q <= rd_ret_ack;
      wr_done_q       <= wr_ret_ack;
      if (rd_ret_ack) begin
        rd_resp_addr_q <= rd_ret_address;
        rd_resp_data_q <= rd_ret_data;
      end
      if (wr_ret_ack) begin
        wr_done_addr_q <= wr_ret_address;
      end
    end
  end

  assign rd_en          = rd_en_q;
  assign wr_en          = wr_en_q;
  assign rd_address     = rd_address_q;
  assign wr_address     = wr_address_q;
  assign wr_data        = wr_data_q;
  assign rd_resp_valid  = rd_resp_valid_q;
  assign rd_resp_addr   = rd_resp_addr_q;
  assign rd_resp_data   = rd_resp_data_q;
  assign wr_done        = wr_done_q;
  assign wr_done_addr   = wr_done_addr_q;
  assign rd_outstanding = rd_out_q;
  assign wr_outstanding = wr_out_q;
  assign proto_err      = proto_err_q;
  assign idle           = ~fifo_nonempty & (rd_out_q == '0) & (wr_out_q == '0);

endmodule

`default_nettype wire
